// File: rtl/uart_telemetry_link.sv
// UART telemetry loop: FIFO-fed 8N1 transmitter, synchronised receiver, 8-byte packet
// assembler and a fixed-point benchmark score computed from the four packet fields.
module uart_telemetry_link #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned SCALE    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_data_in,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic        tx_out,
    output logic        tx_busy,
    input  logic        rx_in,
    output logic        rx_busy,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [15:0] cpu_freq_mhz,
    output logic [15:0] disk_speed_mbps,
    output logic [15:0] memory_usage,
    output logic [15:0] temperature_c,
    output logic [31:0] score,
    output logic        score_valid
);

    localparam int unsigned CPB     = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = $clog2(CPB);
    localparam int unsigned GAP_LIM = 16 * CPB;
    localparam int unsigned GAP_W   = $clog2(GAP_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_LIM);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // ---------------- transmitter ----------------
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_out_d, tx_busy_d, fifo_read_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            fifo_read  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_out     <= tx_out_d;
            tx_busy    <= tx_busy_d;
            fifo_read  <= fifo_read_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    tx_state_d = S_START;
                    tx_byte_d  = fifo_data_in;
                    tx_bit_d   = '0;
                end
            end
            S_START: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so tx_out stays a clean register.
    always_comb begin
        fifo_read_d = (tx_state_q == S_IDLE) && !fifo_empty;
        tx_busy_d   = (tx_state_d != S_IDLE);
        case (tx_state_d)
            S_START: tx_out_d = 1'b0;
            S_DATA:  tx_out_d = tx_byte_d[tx_bit_d];
            default: tx_out_d = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_d;
    logic             rx_valid_d, frame_err_d, rx_busy_d, stop_tick_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
            rx_busy    <= rx_busy_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stop_tick_c = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_LAST);
        rx_valid_d  = stop_tick_c && rx_s2_q;
        frame_err_d = stop_tick_c && !rx_s2_q;
        rx_busy_d   = (rx_state_d != S_IDLE);
        rx_data_d   = rx_valid_d ? rx_shift_q : rx_data;
    end

    // ---------------- packet assembly and scoring ----------------
    logic [2:0]       idx_q, idx_c;
    logic [6:0][7:0]  pkt_q;
    logic [GAP_W-1:0] gap_q;
    logic             calc_q;
    logic [18:0]      base_c;
    logic [6:0]       pen_c;
    logic [47:0]      prod_c, quot_c;
    logic [31:0]      score_c;

    assign idx_c = (gap_q >= GAP_MAX) ? 3'd0 : idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q           <= '0;
            pkt_q           <= '0;
            gap_q           <= '0;
            calc_q          <= 1'b0;
            cpu_freq_mhz    <= '0;
            disk_speed_mbps <= '0;
            memory_usage    <= '0;
            temperature_c   <= '0;
            score           <= '0;
            score_valid     <= 1'b0;
        end else begin
            calc_q <= 1'b0;
            if (rx_valid) begin
                gap_q <= '0;
                if (idx_c == 3'd0) score_valid <= 1'b0;
                if (idx_c == 3'd7) begin
                    cpu_freq_mhz    <= {pkt_q[1], pkt_q[0]};
                    disk_speed_mbps <= {pkt_q[3], pkt_q[2]};
                    memory_usage    <= {pkt_q[5], pkt_q[4]};
                    temperature_c   <= {rx_data, pkt_q[6]};
                    idx_q           <= '0;
                    calc_q          <= 1'b1;
                end else begin
                    pkt_q[idx_c] <= rx_data;
                    idx_q        <= idx_c + 3'd1;
                end
            end else if (idx_q != 3'd0) begin
                // Stalled partial packet: drop it so the next byte starts a fresh packet.
                if (gap_q >= GAP_MAX) begin
                    idx_q <= '0;
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_q + GAP_W'(1);
                end
            end
            if (calc_q) begin
                score       <= score_c;
                score_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        base_c = (19'(cpu_freq_mhz) << 2) + (19'(disk_speed_mbps) << 1) + 19'(memory_usage[15:6]);
        if (temperature_c <= 16'd70)       pen_c = 7'd100;
        else if (temperature_c <= 16'd99)  pen_c = 7'(16'd240 - (temperature_c << 1));
        else if (temperature_c <= 16'd149) pen_c = 7'd25;
        else                               pen_c = 7'd0;
        prod_c  = 48'(base_c) * 48'(pen_c) * 48'(SCALE);
        quot_c  = prod_c / 48'd10000;
        score_c = (quot_c > 48'hFFFF_FFFF) ? 32'hFFFF_FFFF : quot_c[31:0];
    end

endmodule

// File: tb/tb_uart_telemetry_link.sv
// Loopback bench for uart_telemetry_link: FIFO model, bit-level TX model, byte scoreboard
// and a packet/score model checked every cycle, plus literal packet expectations.
module tb_uart_telemetry_link;

    localparam int CPB = 10;
    localparam int GAP = 16 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  fifo_data_in = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_read, tx_out, tx_busy, rx_busy, rx_valid, frame_err, score_valid;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic [15:0] cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c;
    logic [31:0] score;
    logic        rx_sel = 1'b0;
    logic        rx_drv = 1'b1;

    assign rx_in = rx_sel ? rx_drv : tx_out;

    uart_telemetry_link #(.CLK_FREQ(1_000_000), .BAUD(100_000), .SCALE(100)) dut (
        .clk(clk), .rst(rst), .fifo_data_in(fifo_data_in), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in),
        .rx_busy(rx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .cpu_freq_mhz(cpu_freq_mhz), .disk_speed_mbps(disk_speed_mbps),
        .memory_usage(memory_usage), .temperature_c(temperature_c),
        .score(score), .score_valid(score_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_score(input longint cpu, disk, mem, temp);
        longint base, pen, r;
        base = cpu * 4 + disk * 2 + mem / 64;
        if (temp <= 70)       pen = 100;
        else if (temp < 100)  pen = 100 - 2 * (temp - 70);
        else if (temp < 150)  pen = 25;
        else                  pen = 0;
        r = base * pen * 100 / 10000;
        if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
        return r;
    endfunction

    // FIFO contents written by the stimulus, read pointer owned by the model process
    logic [7:0] fifo_mem [256];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    int         ferr_req = 0;

    // model state, owned by the compare process
    logic [7:0] exp_rx [$];
    longint     cyc = 0, tx_start = 0, last_rx = 0;
    longint     clear_at = 0, fields_at = 0, set_at = 0;
    bit         tx_active = 0;
    logic [7:0] tx_byte;
    int         idx = 0, pops = 0, ferr_got = 0;
    logic [7:0] pkt [8];
    logic       exp_sv = 1'b0;
    longint     e_cpu = 0, e_disk = 0, e_mem = 0, e_temp = 0, e_score = 0;
    longint     n_cpu = 0, n_disk = 0, n_mem = 0, n_temp = 0, n_score = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("rst_tx_out", tx_out, 1);
            check("rst_tx_busy", tx_busy, 0);
            check("rst_fifo_read", fifo_read, 0);
            check("rst_rx_busy", rx_busy, 0);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_rx_data", rx_data, 0);
            check("rst_score", score, 0);
            check("rst_score_valid", score_valid, 0);
            check("rst_cpu", cpu_freq_mhz, 0);
            check("rst_temp", temperature_c, 0);
            tx_active = 0; exp_rx.delete(); idx = 0;
            clear_at = 0; fields_at = 0; set_at = 0; exp_sv = 1'b0;
            e_cpu = 0; e_disk = 0; e_mem = 0; e_temp = 0; e_score = 0;
        end else begin
            logic exp_line, exp_busy;
            if (fifo_read) begin
                check("pop_nonempty", fifo_rd != fifo_wr, 1);
                check("pop_idle_gap", !tx_active || (cyc - tx_start > 10 * CPB), 1);
                tx_byte = fifo_mem[fifo_rd];
                fifo_rd++;
                pops++;
                tx_start = cyc;
                tx_active = 1;
                exp_rx.push_back(tx_byte);
            end
            exp_line = 1'b1;
            exp_busy = 1'b0;
            if (tx_active && (cyc - tx_start < 10 * CPB)) begin
                int k;
                k = int'((cyc - tx_start) / CPB);
                exp_busy = 1'b1;
                if (k == 0)      exp_line = 1'b0;
                else if (k == 9) exp_line = 1'b1;
                else             exp_line = tx_byte[k-1];
            end
            check("tx_line", tx_out, exp_line);
            check("tx_busy", tx_busy, exp_busy);

            if (rx_valid) begin
                check("rx_valid_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    logic [7:0] e;
                    e = exp_rx.pop_front();
                    check("rx_byte", rx_data, e);
                    if (idx != 0 && (cyc - last_rx > GAP)) idx = 0;
                    last_rx = cyc;
                    if (idx == 0) clear_at = cyc + 1;
                    pkt[idx] = e;
                    if (idx == 7) begin
                        n_cpu  = pkt[1] * 256 + pkt[0];
                        n_disk = pkt[3] * 256 + pkt[2];
                        n_mem  = pkt[5] * 256 + pkt[4];
                        n_temp = pkt[7] * 256 + pkt[6];
                        n_score = model_score(n_cpu, n_disk, n_mem, n_temp);
                        fields_at = cyc + 1;
                        set_at = cyc + 2;
                        idx = 0;
                    end else begin
                        idx++;
                    end
                end
            end
            if (frame_err) begin
                check("frame_err_expected", ferr_got < ferr_req, 1);
                ferr_got++;
            end

            if (cyc == clear_at) exp_sv = 1'b0;
            if (cyc == fields_at) begin
                e_cpu = n_cpu; e_disk = n_disk; e_mem = n_mem; e_temp = n_temp;
            end
            if (cyc == set_at) begin
                exp_sv = 1'b1;
                e_score = n_score;
            end
            check("score_valid", score_valid, exp_sv);
            check("cpu_field", cpu_freq_mhz, e_cpu);
            check("disk_field", disk_speed_mbps, e_disk);
            check("mem_field", memory_usage, e_mem);
            check("temp_field", temperature_c, e_temp);
            if (exp_sv) check("score", score, e_score);
        end
        fifo_empty   = (fifo_rd == fifo_wr);
        fifo_data_in = fifo_mem[fifo_rd];
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[fifo_wr] = b;
        fifo_wr++;
    endtask

    task automatic wait_tx_idle(input int max);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!(fifo_empty && !tx_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", n < max, 1);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic run_pkt(input string tag, input logic [7:0] b [8], input longint x_cpu,
                           input longint x_disk, input longint x_mem, input longint x_temp,
                           input longint x_score);
        for (int i = 0; i < 8; i++) push(b[i]);
        wait_tx_idle(8 * 12 * CPB);
        repeat (4) @(negedge clk);
        check({tag, "_cpu"}, cpu_freq_mhz, x_cpu);
        check({tag, "_disk"}, disk_speed_mbps, x_disk);
        check({tag, "_mem"}, memory_usage, x_mem);
        check({tag, "_temp"}, temperature_c, x_temp);
        check({tag, "_score"}, score, x_score);
        check({tag, "_valid"}, score_valid, 1);
    endtask

    logic [7:0] temps [4]   = '{8'd99, 8'd150, 8'd149, 8'd71};
    longint     t_score [4] = '{1680, 0, 1000, 3920};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx_out", tx_out, 1);
        check("reset_score_valid", score_valid, 0);
        @(posedge clk); #3 rst = 1'b1;
        repeat (5) @(negedge clk);

        push(8'hA5);
        wait_tx_idle(20 * CPB);
        repeat (5) @(negedge clk);
        check("a5_pop_count", pops, 1);
        check("a5_rx_data", rx_data, 8'hA5);
        repeat (400) @(negedge clk);

        run_pkt("pkt1", '{8'h94, 8'h11, 8'hD0, 8'h07, 8'h00, 8'h40, 8'h46, 8'h00},
                4500, 2000, 16384, 70, 22256);

        rx_sel = 1'b1;
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        ferr_req = 1;
        send_raw(8'h5A, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        rx_sel = 1'b0;
        check("ferr_count", ferr_got, 1);
        check("ferr_rx_data_kept", rx_data, 8'h00);
        check("ferr_score_valid_held", score_valid, 1);
        check("ferr_score_held", score, 22256);

        run_pkt("pkt2", '{8'h48, 8'h0D, 8'h26, 8'h02, 8'h00, 8'h40, 8'h69, 8'h00},
                3400, 550, 16384, 105, 3739);

        push(8'h11); push(8'h22); push(8'h33);
        wait_tx_idle(4 * 12 * CPB);
        repeat (400) @(negedge clk);
        run_pkt("pkt3", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00},
                0, 0, 0, 255, 0);

        for (int i = 0; i < 4; i++)
            run_pkt($sformatf("temp%0d", temps[i]),
                    '{8'hE8, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, temps[i], 8'h00},
                    1000, 0, 0, temps[i], t_score[i]);

        push(8'h3C);
        repeat (15) @(negedge clk);
        check("pre_reset_line_low", tx_out, 0);
        @(posedge clk); #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_tx_out", tx_out, 1);
        check("midrst_score_valid", score_valid, 0);
        @(posedge clk); #3 rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_resend", tx_busy, 0);

        run_pkt("pkt1b", '{8'h94, 8'h11, 8'hD0, 8'h07, 8'h00, 8'h40, 8'h46, 8'h00},
                4500, 2000, 16384, 70, 22256);

        repeat (20) @(negedge clk);
        check("rx_scoreboard_drained", exp_rx.size(), 0);
        check("frame_err_total", ferr_got, ferr_req);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
